// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial WIDTH-bit subtractor computing a - b, LSB first, using a single
//   full-subtractor cell and a registered borrow. A start/busy/done handshake
//   launches an operation and presents the difference and final borrow.
//
// Ports:
//   clk        - rising-edge clock
//   rst_n      - asynchronous active-low reset
//   start      - request an operation (sampled only in IDLE)
//   a, b       - minuend / subtrahend, captured on an accepted start
//   busy       - high while bits are being processed (SHIFT)
//   done       - one-cycle pulse when diff/borrow_out are fresh
//   diff       - a - b modulo 2^WIDTH, held until the next operation's DONE
//   borrow_out - final borrow (1 when unsigned a < b), held likewise
// ---------------------------------------------------------------------------
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res;
    logic [CW-1:0]    cnt;
    logic             br;

    logic             d;
    logic             br_next;
    logic [WIDTH-1:0] res_next;

    // Full-subtractor cell operating on the current LSBs.
    always_comb begin
        d        = sa[0] ^ sb[0] ^ br;
        br_next  = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
        res_next = {d, res[WIDTH-1:1]};
    end

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sa         <= '0;
            sb         <= '0;
            res        <= '0;
            cnt        <= '0;
            br         <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        br    <= 1'b0;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    br  <= br_next;
                    res <= res_next;
                    if (cnt == LAST) begin
                        // Outputs are loaded on the final bit's edge so they
                        // stay stable throughout SHIFT and are valid in DONE.
                        diff       <= res_next;
                        borrow_out <= br_next;
                        state      <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;

    int checks;
    int failures;

    logic [W-1:0] last_diff;
    logic         last_bo;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Launch one operation and check every cycle through DONE and back to IDLE.
    // inject >= 0: pulse start with other operands during that SHIFT cycle.
    task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic [W-1:0] ed, input logic eb, input int inject);
        @(negedge clk);
        a = ta; b = tb_v; start = 1'b1;
        @(posedge clk);            // accepting edge k
        for (int j = 0; j <= W + 1; j++) begin
            @(negedge clk);
            if (j == 0) begin
                start = 1'b0;
                a = ~ta; b = ~tb_v;    // operands changing after capture
            end
            if (j == inject) begin
                start = 1'b1; a = 8'hAA; b = 8'h55;
            end else if (j == inject + 1) begin
                start = 1'b0;
            end
            if (j < W) begin
                check({tag, "_busy"}, 32'(busy), 32'd1);
                check({tag, "_nodone"}, 32'(done), 32'd0);
                check({tag, "_hold_diff"}, 32'(diff), 32'(last_diff));
                check({tag, "_hold_bo"}, 32'(borrow_out), 32'(last_bo));
            end else if (j == W) begin
                check({tag, "_busy_end"}, 32'(busy), 32'd0);
                check({tag, "_done"}, 32'(done), 32'd1);
                check({tag, "_diff"}, 32'(diff), 32'(ed));
                check({tag, "_bo"}, 32'(borrow_out), 32'(eb));
            end else begin
                check({tag, "_idle_busy"}, 32'(busy), 32'd0);
                check({tag, "_idle_done"}, 32'(done), 32'd0);
                check({tag, "_idle_diff"}, 32'(diff), 32'(ed));
            end
        end
        last_diff = ed;
        last_bo   = eb;
    endtask

    initial begin
        checks = 0; failures = 0;
        last_diff = '0; last_bo = 1'b0;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;

        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_bo", 32'(borrow_out), 32'd0);
        rst_n = 1'b1;

        run_op("s05_03", 8'h05, 8'h03, 8'h02, 1'b0, -1);
        run_op("s03_05", 8'h03, 8'h05, 8'hFE, 1'b1, -1);
        run_op("s00_00", 8'h00, 8'h00, 8'h00, 1'b0, -1);
        run_op("s80_FF", 8'h80, 8'hFF, 8'h81, 1'b1, -1);
        run_op("sFF_01", 8'hFF, 8'h01, 8'hFE, 1'b0, -1);

        // start during SHIFT cycle 3 is ignored: no extra done afterwards
        run_op("s10_01", 8'h10, 8'h01, 8'h0F, 1'b0, 2);
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            check("ign_nodone", 32'(done), 32'd0);
            check("ign_nobusy", 32'(busy), 32'd0);
        end

        // reset mid-operation, in SHIFT cycle 4
        @(negedge clk);
        a = 8'h44; b = 8'h11; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_busy_pre", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_diff", 32'(diff), 32'd0);
        check("abort_bo", 32'(borrow_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        last_diff = '0; last_bo = 1'b0;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            check("abort_nodone", 32'(done), 32'd0);
        end
        run_op("s09_04", 8'h09, 8'h04, 8'h05, 1'b0, -1);

        // start held high: results every W+2 cycles
        @(negedge clk);
        a = 8'h20; b = 8'h01; start = 1'b1;
        @(posedge clk);
        for (int j = 0; j < 2 * W + 4; j++) begin
            @(negedge clk);
            check("b2b_done", 32'(done), 32'((j == W) || (j == 2 * W + 2)));
            check("b2b_busy", 32'(busy), 32'((j < W) || (j >= W + 2 && j < 2 * W + 2)));
            if (j == W || j == 2 * W + 2) begin
                check("b2b_diff", 32'(diff), 32'h1F);
                check("b2b_bo", 32'(borrow_out), 32'd0);
            end
            if (j == 2 * W + 3) start = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial N-bit subtractor that computes `a - b` one bit per clock, LSB first. It uses a single full-subtractor cell and a registered borrow flip-flop, and performs the inverse operation of the lab's full-adder datapath. A start/busy/done handshake lets a controller or testbench launch an operation and collect the difference and final borrow after a fixed latency.

## Interface
- `WIDTH`, default 8: operand and result width in bits, minimum 2.

- `clk`  input  1: rising-edge clock.
- `rst_n`  input  1: asynchronous active-low reset.
- `start`  input  1: request an operation; sampled only in IDLE.
- `a`  input  WIDTH: minuend; captured on an accepted start.
- `b`  input  WIDTH: subtrahend; captured on an accepted start.
- `busy`  output  1: high while in SHIFT.
- `done`  output  1: one-cycle pulse when the result is valid.
- `diff`  output  WIDTH: `a - b` modulo 2^WIDTH.
- `borrow_out`  output  1: final borrow; 1 when unsigned `a < b`.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - On `start == 1`: load `a` into shift register `sa` and `b` into `sb`, clear the borrow flip-flop `br`, clear the bit counter `cnt`, then go to SHIFT.
  - Otherwise: stay in IDLE and hold `diff` and `borrow_out` unchanged.
- SHIFT, each cycle:
  - `d = sa[0] ^ sb[0] ^ br`
  - `br_next = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br)`
  - Shift `sa` and `sb` right by 1.
  - Shift `d` into the MSB of the result shift register.
  - Increment `cnt`.
  - When `cnt == WIDTH-1`, go to DONE on this edge.
- DONE:
  - `diff` is driven from the result register and `borrow_out` from `br`.
  - `done` is 1.
  - Go to IDLE unconditionally after one cycle.
- `start` is ignored in SHIFT and DONE. No queuing: a `start` held high through DONE is accepted again on the first IDLE cycle.
- `diff` and `borrow_out` hold the last result until the next operation's DONE. They do not change during SHIFT.
- `cnt` width is `$clog2(WIDTH)`. The counter does not wrap beyond WIDTH-1.
- Operands are unsigned. The signed result is the same bit pattern, and signed overflow is not flagged.

## Timing
- Reset (`rst_n == 0`, asynchronous): state IDLE, `busy = 0`, `done = 0`, `diff = 0`, `borrow_out = 0`, all internal registers cleared.
- Reset release is synchronous in effect: the first edge with `rst_n == 1` may accept `start`.
- `start` sampled high at edge k in IDLE:
  - `busy = 1` from edge k through edge k+WIDTH.
  - Bits 0..WIDTH-1 are processed on edges k+1..k+WIDTH.
  - `done = 1` and a valid `diff` appear after edge k+WIDTH, for exactly one cycle.
  - After edge k+WIDTH+1, the FSM is in IDLE with `done = 0`.
- Latency from start to done: WIDTH+1 cycles. Minimum start-to-start spacing: WIDTH+2 cycles.
- `busy` and `done` are never high in the same cycle.
- Reset asserted mid-operation aborts immediately. All outputs take their reset values and no `done` pulse is produced.
- `a` and `b` may change freely after the accepting edge without affecting the result.

## Test plan
- After reset, with WIDTH=8: `a = 8'h05`, `b = 8'h03`, start pulse -> `done` in cycle 9 after start, `diff = 8'h02`, `borrow_out = 0`, `busy` high for exactly 8 cycles.
- `a = 8'h03`, `b = 8'h05` -> `diff = 8'hFE`, `borrow_out = 1`.
- Edge operands:
  - `8'h00 - 8'h00` -> `diff = 8'h00`, `borrow_out = 0`.
  - `8'h80 - 8'hFF` -> `diff = 8'h81`, `borrow_out = 1`.
  - `8'hFF - 8'h01` -> `diff = 8'hFE`, `borrow_out = 0`.
- Start `8'h10 - 8'h01`, then pulse `start` with `a = 8'hAA`, `b = 8'h55` in cycle 3 of SHIFT -> first result `diff = 8'h0F` is unaffected, and no second `done` pulse occurs.
- Start an operation, then assert `rst_n = 0` in cycle 4 of SHIFT:
  - All outputs go to 0 immediately and no `done` pulse is produced.
  - After release, `8'h09 - 8'h04` -> `diff = 8'h05`.
- Hold `start` high continuously with `a = 8'h20`, `b = 8'h01` -> back-to-back results `diff = 8'h1F` with `done` pulses exactly WIDTH+2 = 10 cycles apart.
